button_pulse_gen: RTL and testbench

Upstream conditioning stage for the 2-bit binary counter: takes a raw, asynchronous, bouncing push-button level and produces a clean one-clock-cycle pulse per accepted press. The pulse drives the counter's count-enable input `x`. The debounced level is also exported for LEDs and other consumers. Synchronisation, debounce filtering and edge extraction all live in this block, so the counter only ever sees synchronous, single-cycle enables.

---
 rtl/btn_pkg.sv | 15 +
 rtl/sync_2ff.sv | 30 +++
 rtl/button_pulse_gen.sv | 101 ++++++++++
 tb/tb_button_pulse_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encoding and the default debounce lengths for simulation and board builds.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b11,
    ST_RELEASE_WAIT = 2'b10
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;
  localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reusable for any slow board-level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;

  always_comb begin
    s0_d = d;
    s1_d = s0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign q = s1_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Turns a raw bouncing push-button level into a debounced level and a single
// one-cycle pulse per accepted press (the count enable for binary_counter.x).
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | synchronised input high, counting towards acceptance
// HELD         | press accepted, button still down
// RELEASE_WAIT | synchronised input low, counting towards release
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered level tracks the state being entered, so it changes on the same edge.
    level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen at N=4 and N=1, driven by directed
// scenarios plus random button waveforms against a run-length reference model.
`timescale 1ns/1ps
module tb_button_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic pulse, level;
  logic pulse1, level1;

  int n_checks = 0;
  int n_errors = 0;

  button_pulse_gen #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse), .level(level)
  );

  button_pulse_gen #(.DEBOUNCE_CYCLES(1)) u_dut_n1 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse1), .level(level1)
  );

  always #64 clk = ~clk;

  // Reference model: btn_s is btn_in delayed two edges; the debounced level
  // flips once N+1 consecutive btn_s samples disagree with it.
  int nval[2] = '{4, 1};
  int m_run[2];
  bit m_lvl[2];
  bit m_pls[2];
  bit h0, h1;

  int ecnt, first_p, first_p1, npulse, fall_e;
  bit lvl_hi_seen, lvl_lo_seen;
  logic prev_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    h0 = 1'b0;
    h1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0;
      m_lvl[i] = 1'b0;
      m_pls[i] = 1'b0;
    end
  endtask

  task automatic clear_stats();
    ecnt        = 0;
    first_p     = 0;
    first_p1    = 0;
    npulse      = 0;
    fall_e      = 0;
    lvl_hi_seen = 1'b0;
    lvl_lo_seen = 1'b0;
    prev_lvl    = level;
  endtask

  task automatic run_cycle(input logic b);
    bit fsm_in;
    btn_in = b;
    @(posedge clk);
    #1;
    fsm_in = h1;
    h1 = h0;
    h0 = b;
    for (int i = 0; i < 2; i++) begin
      m_pls[i] = 1'b0;
      if (fsm_in != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == nval[i] + 1) begin
        m_lvl[i] = fsm_in;
        m_run[i] = 0;
        m_pls[i] = fsm_in;
      end
    end
    check("pulse", pulse, m_pls[0]);
    check("level", level, m_lvl[0]);
    check("pulse_n1", pulse1, m_pls[1]);
    check("level_n1", level1, m_lvl[1]);
    ecnt++;
    if (pulse === 1'b1) begin
      npulse++;
      if (first_p == 0) first_p = ecnt;
    end
    if (pulse1 === 1'b1 && first_p1 == 0) first_p1 = ecnt;
    if (level === 1'b1) lvl_hi_seen = 1'b1;
    if (level === 1'b0) lvl_lo_seen = 1'b1;
    if (prev_lvl === 1'b1 && level === 1'b0 && fall_e == 0) fall_e = ecnt;
    prev_lvl = level;
  endtask

  task automatic run_level(input logic b, input int n);
    for (int i = 0; i < n; i++) run_cycle(b);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #20;
    rst = 1'b1;
    #2;
    check("rst_pulse", pulse, 0);
    check("rst_level", level, 0);
    check("rst_pulse_n1", pulse1, 0);
    check("rst_level_n1", level1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int exp_z[5] = '{1, 2, 3, 0, 1};
  int z_total;

  initial begin
    model_reset();
    #2;
    check("reset_pulse", pulse, 0);
    check("reset_level", level, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean press held for 20 cycles
    clear_stats();
    run_level(1'b1, 20);
    check("clean_pulse_edge", first_p, 7);
    check("clean_pulse_count", npulse, 1);
    check("clean_level_held", level, 1);
    check("n1_pulse_edge", first_p1, 4);
    clear_stats();
    run_level(1'b0, 12);
    check("clean_release_edge", fall_e, 7);

    // Bounce reject
    clear_stats();
    for (int i = 0; i < 6; i++) run_cycle((i % 2) == 0);
    run_level(1'b0, 10);
    check("bounce_pulses", npulse, 0);
    check("bounce_level_seen", lvl_hi_seen, 0);

    // Release bounce while held
    run_level(1'b1, 12);
    clear_stats();
    run_level(1'b0, 2);
    run_level(1'b1, 8);
    check("relbounce_pulses", npulse, 0);
    check("relbounce_level_dropped", lvl_lo_seen, 0);
    clear_stats();
    run_level(1'b0, 12);
    check("final_release_edge", fall_e, 7);

    // Counter chain: 5 presses advance a 2-bit count once each
    z_total = 0;
    for (int p = 0; p < 5; p++) begin
      clear_stats();
      run_level(1'b1, 10);
      run_level(1'b0, 10);
      z_total += npulse;
      check("chain_z", z_total % 4, exp_z[p]);
    end

    // Reset during PRESS_WAIT with cnt=2, button still held afterwards
    clear_stats();
    run_level(1'b1, 5);
    do_reset();
    clear_stats();
    run_level(1'b1, 12);
    check("post_reset_pulse_edge", first_p, 7);
    check("post_reset_pulse_count", npulse, 1);

    // Reset while HELD must drop level immediately
    check("held_before_reset", level, 1);
    do_reset();
    run_level(1'b0, 10);

    // Random button waveforms with occasional resets
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      run_level(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
